sram_sinc_param: RTL and testbench
==================================

SRAM_SINC_PARAM -- requirements
Module: sram_sinc_param

Interface
REQ-001 Parameter ANCHO, default 8, data word width in bits (1..64).
REQ-002 Parameter PROF, default 12, number of words (2..256).
REQ-003 Parameter ANCHO_DIR, default 8, address width in bits; PROF SHALL be at most 2^ANCHO_DIR.
REQ-004 Parameter LAT, default 1, read latency in cycles (1 or 2).
REQ-005 Port clk, input, 1, single clock; all state SHALL update on the rising edge only.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port En, input, 1, access request; sampled only when Ocupado=0.
REQ-008 Port We, input, 1, 1 means write and 0 means read; qualified by En.
REQ-009 Port Dir, input, ANCHO_DIR, word address.
REQ-010 Port Dato_e, input, ANCHO, write data.
REQ-011 Port Iny_par, input, 1, parity-fault injection on write (see Configuration).
REQ-012 Port Dato_s, output, ANCHO, registered read data.
REQ-013 Port Valido, output, 1, one-cycle pulse marking Dato_s as fresh.
REQ-014 Port Ocupado, output, 1, high while the clear sweep runs; requests are ignored while it is high.
REQ-015 Port Err_dir, output, 1, one-cycle pulse for an out-of-range access.
REQ-016 Port Err_par, output, 1, one-cycle pulse for a read parity mismatch.

Function
REQ-017 The FSM SHALL have two states: BORRADO and LISTO.
REQ-018 BORRADO: a counter SHALL write 0 to address 0..PROF-1, one word per cycle, then move to LISTO.
REQ-019 Ocupado SHALL be 1 for exactly PROF cycles after rst deasserts.
REQ-020 In LISTO, En=1 with We=1 and Dir<PROF SHALL write Dato_e to RAM[Dir] at that edge; there is no Valido for writes.
REQ-021 In LISTO, En=1 with We=0 SHALL drive RAM[Dir] on Dato_s with Valido=1 exactly LAT cycles after the sampling edge.
REQ-022 Reads SHALL be fully pipelined: one request per cycle, responses returned in order.
REQ-023 Dato_s SHALL hold its last value whenever Valido=0.
REQ-024 A read in the cycle after a write to the same address SHALL return the new data.
REQ-025 A write with Dir>=PROF SHALL leave memory unchanged and pulse Err_dir one cycle later.
REQ-026 A read with Dir>=PROF SHALL return Dato_s=0 with Valido=1 and Err_dir=1, both LAT cycles later.
REQ-027 En=0 SHALL have no effect; We, Dir and Dato_e are then don't-care.

Reset
REQ-028 rst=1 SHALL set Dato_s=0, Valido=0, Err_dir=0, Err_par=0, Ocupado=1, the counter to 0 and the state to BORRADO.
REQ-029 A reset that lands mid-read or mid-sweep SHALL flush the read pipeline (no Valido for pending reads) and restart the sweep from address 0.
REQ-030 Memory contents are undefined only until the sweep completes.

Configuration
REQ-031 Macro SRAM_PARIDAD_EN: when defined, each word SHALL store an extra even-parity bit, computed as the XOR of Dato_e inverted when Iny_par=1.
REQ-032 With SRAM_PARIDAD_EN defined, the sweep SHALL write a correct parity bit, and Err_par SHALL pulse together with Valido when the stored parity does not match the data read.
REQ-033 With SRAM_PARIDAD_EN undefined, no parity storage SHALL exist, Err_par SHALL be constant 0 and Iny_par SHALL be ignored.

Verification
REQ-034 Sweep: release rst, PROF=12 -> Ocupado=1 for 12 cycles; then reads of addresses 0..11 -> all Dato_s=0.
REQ-035 Write then read: write 8'd90 to Dir=0, then read Dir=0, LAT=1 -> Dato_s=90 with Valido=1 one cycle after the read edge; with LAT=2, two cycles after.
REQ-036 Streaming: write 10,20,30 to addresses 3,4,5, then back-to-back reads 3,4,5 -> Valido high 3 consecutive cycles with data 10,20,30.
REQ-037 Range: write 8'd77 to Dir=12 -> Err_dir pulse and RAM unchanged; read Dir=200 -> Dato_s=0, Valido=1, Err_dir=1.
REQ-038 Reset mid-op: issue a read with LAT=2 and assert rst the next cycle -> no Valido, and Ocupado=1 for 12 cycles again.
REQ-039 Parity (macro defined): write 8'h55 with Iny_par=1, then read -> Err_par=1 with Valido=1; write again with Iny_par=0 and read -> Err_par=0.

Source files
------------

// File: rtl/sram_sinc_param.sv
// Synchronous single-port SRAM with a clear sweep after reset, a pipelined
// read path (latency LAT = 1 or 2) and out-of-range detection.
// Optional feature: define SRAM_PARIDAD_EN to store one even-parity bit per
// word and report read parity mismatches on Err_par.
module sram_sinc_param #(
  parameter int ANCHO     = 8,
  parameter int PROF      = 12,
  parameter int ANCHO_DIR = 8,
  parameter int LAT       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 En,
  input  logic                 We,
  input  logic [ANCHO_DIR-1:0] Dir,
  input  logic [ANCHO-1:0]     Dato_e,
  input  logic                 Iny_par,
  output logic [ANCHO-1:0]     Dato_s,
  output logic                 Valido,
  output logic                 Ocupado,
  output logic                 Err_dir,
  output logic                 Err_par
);

  localparam int IW = (PROF > 1) ? $clog2(PROF) : 1;
`ifdef SRAM_PARIDAD_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int WT = ANCHO + PW;

  // PROF widened by one bit so that PROF == 2^ANCHO_DIR still compares correctly
  localparam logic [ANCHO_DIR:0] PROF_EXT = (ANCHO_DIR + 1)'(PROF);
  localparam logic [IW-1:0]      CNT_LAST = IW'(PROF - 1);

  typedef enum logic {BORRADO, LISTO} estado_t;

  estado_t        state_reg, state_next;
  logic [IW-1:0]  cnt_reg, cnt_next;

  logic           en_ok, in_range, rd_acc, wr_acc;
  logic [IW-1:0]  idx;
  logic [WT-1:0]  wr_word;

  logic           mem_we;
  logic [IW-1:0]  mem_wa;
  logic [WT-1:0]  mem_wd;
  logic [WT-1:0]  mem [PROF];

  logic [WT-1:0]  rd_reg;
  logic           s1_vld_reg, s1_oor_reg, wr_err_reg;

  logic [WT-1:0]  out_word;
  logic           out_vld, out_oor;

  assign Ocupado  = (state_reg == BORRADO);
  assign en_ok    = En & ~rst & (state_reg == LISTO);
  assign in_range = ({1'b0, Dir} < PROF_EXT);
  assign rd_acc   = en_ok & ~We;
  assign wr_acc   = en_ok & We;
  // Only meaningful when in_range; the upper address bits feed the range compare
  assign idx      = Dir[IW-1:0];

`ifdef SRAM_PARIDAD_EN
  // Stored parity makes the whole word XOR to zero; Iny_par flips it to plant a fault
  assign wr_word = {(^Dato_e) ^ Iny_par, Dato_e};
`else
  logic unused_iny_par;
  assign unused_iny_par = Iny_par;
  assign wr_word        = Dato_e;
`endif

  // State register and sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BORRADO;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: walk the counter over every word, then accept requests
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      BORRADO: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = LISTO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Single write port shared by the clear sweep and user writes
  always_comb begin
    mem_we = 1'b0;
    mem_wa = cnt_reg;
    mem_wd = '0;
    if (state_reg == BORRADO && !rst) begin
      mem_we = 1'b1;
    end else if (wr_acc && in_range) begin
      mem_we = 1'b1;
      mem_wa = idx;
      mem_wd = wr_word;
    end
  end

  // RAM array write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // First read stage: registered RAM output plus request tags
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_reg     <= '0;
      s1_vld_reg <= 1'b0;
      s1_oor_reg <= 1'b0;
      wr_err_reg <= 1'b0;
    end else begin
      s1_vld_reg <= rd_acc;
      s1_oor_reg <= rd_acc & ~in_range;
      wr_err_reg <= wr_acc & ~in_range;
      if (rd_acc) begin
        rd_reg <= in_range ? mem[idx] : '0;
      end
    end
  end

  generate
    if (LAT == 1) begin : g_lat1
      // The RAM output register is the data output; it only loads on reads
      assign out_word = rd_reg;
      assign out_vld  = s1_vld_reg;
      assign out_oor  = s1_oor_reg;
    end else begin : g_lat2
      logic [WT-1:0] s2_word_reg;
      logic          s2_vld_reg, s2_oor_reg;

      // Second stage only loads when a response arrives, so Dato_s holds otherwise
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_word_reg <= '0;
          s2_vld_reg  <= 1'b0;
          s2_oor_reg  <= 1'b0;
        end else begin
          s2_vld_reg <= s1_vld_reg;
          s2_oor_reg <= s1_oor_reg;
          if (s1_vld_reg) begin
            s2_word_reg <= rd_reg;
          end
        end
      end

      assign out_word = s2_word_reg;
      assign out_vld  = s2_vld_reg;
      assign out_oor  = s2_oor_reg;
    end
  endgenerate

  assign Dato_s  = out_word[ANCHO-1:0];
  assign Valido  = out_vld;
  // Write errors report after one cycle, read errors after LAT; both share the pin
  assign Err_dir = out_oor | wr_err_reg;
`ifdef SRAM_PARIDAD_EN
  assign Err_par = out_vld & (^out_word);
`else
  assign Err_par = 1'b0;
`endif

endmodule

// File: tb/tb_sram_sinc_param.sv
// Directed bench for sram_sinc_param: one instance with LAT=1 and one with
// LAT=2 share the same stimulus; outputs are checked 1 ns after each edge.
module tb_sram_sinc_param;

  logic       clk = 1'b0;
  logic       rst, en, we, iny;
  logic [7:0] dir, din;
  logic [7:0] d1, d2;
  logic       v1, v2, oc1, oc2, ed1, ed2, ep1, ep2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_sinc_param #(.ANCHO(8), .PROF(12), .ANCHO_DIR(8), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .En(en), .We(we), .Dir(dir), .Dato_e(din),
    .Iny_par(iny), .Dato_s(d1), .Valido(v1), .Ocupado(oc1),
    .Err_dir(ed1), .Err_par(ep1)
  );

  sram_sinc_param #(.ANCHO(8), .PROF(12), .ANCHO_DIR(8), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .En(en), .We(we), .Dir(dir), .Dato_e(din),
    .Iny_par(iny), .Dato_s(d2), .Valido(v2), .Ocupado(oc2),
    .Err_dir(ed2), .Err_par(ep2)
  );

  typedef struct {
    logic       en, we;
    logic [7:0] dir, din;
    logic       ev1;
    logic [7:0] ed1;
    logic       ee1;
    logic       ev2;
    logic [7:0] ed2;
    logic       ee2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic e, input logic w, input logic [7:0] a, input logic [7:0] d,
                     input logic xv1, input logic [7:0] xd1, input logic xe1,
                     input logic xv2, input logic [7:0] xd2, input logic xe2);
    vec_t t;
    t.en = e; t.we = w; t.dir = a; t.din = d;
    t.ev1 = xv1; t.ed1 = xd1; t.ee1 = xe1;
    t.ev2 = xv2; t.ed2 = xd2; t.ee2 = xe2;
    vecs.push_back(t);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after rst release until Ocupado drops; also flags any Valido
  task automatic count_sweep(output int n, output logic saw_valid);
    n = 0;
    saw_valid = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step();
      saw_valid = saw_valid | v1 | v2;
      if (!oc1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int   n;
    logic sv;

    rst = 1'b1; en = 1'b0; we = 1'b0; dir = 8'd0; din = 8'd0; iny = 1'b0;

    // Table: inputs, then LAT=1 {Valido, Dato_s, Err_dir}, LAT=2 {Valido, Dato_s, Err_dir}
    add(1, 0, 8'd0,   8'd0,  1, 8'd0,  0, 0, 8'd0,  0);
    add(1, 0, 8'd11,  8'd0,  1, 8'd0,  0, 1, 8'd0,  0);
    add(1, 1, 8'd0,   8'd90, 0, 8'd0,  0, 1, 8'd0,  0);
    add(1, 0, 8'd0,   8'd0,  1, 8'd90, 0, 0, 8'd0,  0);
    add(0, 1, 8'd7,   8'd1,  0, 8'd90, 0, 1, 8'd90, 0);
    add(1, 1, 8'd3,   8'd10, 0, 8'd90, 0, 0, 8'd90, 0);
    add(1, 1, 8'd4,   8'd20, 0, 8'd90, 0, 0, 8'd90, 0);
    add(1, 1, 8'd5,   8'd30, 0, 8'd90, 0, 0, 8'd90, 0);
    add(1, 0, 8'd3,   8'd0,  1, 8'd10, 0, 0, 8'd90, 0);
    add(1, 0, 8'd4,   8'd0,  1, 8'd20, 0, 1, 8'd10, 0);
    add(1, 0, 8'd5,   8'd0,  1, 8'd30, 0, 1, 8'd20, 0);
    add(0, 0, 8'd0,   8'd0,  0, 8'd30, 0, 1, 8'd30, 0);
    add(1, 1, 8'd12,  8'd77, 0, 8'd30, 1, 0, 8'd30, 1);
    add(1, 0, 8'd0,   8'd0,  1, 8'd90, 0, 0, 8'd30, 0);
    add(1, 0, 8'd200, 8'd0,  1, 8'd0,  1, 1, 8'd90, 0);
    add(0, 0, 8'd0,   8'd0,  0, 8'd0,  0, 1, 8'd0,  1);
    add(1, 0, 8'd4,   8'd0,  1, 8'd20, 0, 0, 8'd0,  0);
    add(0, 0, 8'd0,   8'd0,  0, 8'd20, 0, 1, 8'd20, 0);
    add(1, 1, 8'd5,   8'd99, 0, 8'd20, 0, 0, 8'd20, 0);
    add(1, 0, 8'd5,   8'd0,  1, 8'd99, 0, 0, 8'd20, 0);
    add(0, 0, 8'd0,   8'd0,  0, 8'd99, 0, 1, 8'd99, 0);

    // Reset state
    repeat (3) step();
    chk("rst_dato1", d1, 8'd0);
    chk("rst_dato2", d2, 8'd0);
    chk("rst_valido", {v1, v2}, 2'b00);
    chk("rst_ocupado", {oc1, oc2}, 2'b11);
    chk("rst_errdir", {ed1, ed2}, 2'b00);
    chk("rst_errpar", {ep1, ep2}, 2'b00);

    // Sweep length; a write request held during the sweep must be ignored
    rst = 1'b0; en = 1'b1; we = 1'b1; dir = 8'd0; din = 8'hFF;
    count_sweep(n, sv);
    $display("sweep: ocupado cycles=%0d", n);
    chk("sweep_len", n, 12);
    chk("sweep_no_valid", sv, 1'b0);
    chk("sweep_lat2_ocupado", oc2, 1'b0);

    // Every word reads back as zero, back-to-back
    for (int k = 0; k <= 12; k++) begin
      en = (k < 12); we = 1'b0; dir = 8'(k);
      step();
      $display("sweep read %0d: v1=%0b d1=%0d v2=%0b d2=%0d", k, v1, d1, v2, d2);
      if (k < 12) begin
        chk("clr_v1", v1, 1'b1);
        chk("clr_d1", d1, 8'd0);
      end
      if (k > 0) begin
        chk("clr_v2", v2, 1'b1);
        chk("clr_d2", d2, 8'd0);
      end
    end

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; we = vecs[i].we; dir = vecs[i].dir; din = vecs[i].din;
      step();
      $display("vec %0d en=%0b we=%0b dir=%0d din=%0d -> v1=%0b d1=%0d e1=%0b v2=%0b d2=%0d e2=%0b",
               i, en, we, dir, din, v1, d1, ed1, v2, d2, ed2);
      chk($sformatf("v%0d_valido1", i), v1, vecs[i].ev1);
      chk($sformatf("v%0d_dato1", i), d1, vecs[i].ed1);
      chk($sformatf("v%0d_errdir1", i), ed1, vecs[i].ee1);
      chk($sformatf("v%0d_valido2", i), v2, vecs[i].ev2);
      chk($sformatf("v%0d_dato2", i), d2, vecs[i].ed2);
      chk($sformatf("v%0d_errdir2", i), ed2, vecs[i].ee2);
      chk($sformatf("v%0d_ocupado", i), {oc1, oc2}, 2'b00);
      chk($sformatf("v%0d_errpar", i), {ep1, ep2}, 2'b00);
    end

    // Reset lands while a LAT=2 read is in flight
    en = 1'b1; we = 1'b0; dir = 8'd5;
    step();
    $display("midop read: v1=%0b d1=%0d", v1, d1);
    chk("midop_v1", v1, 1'b1);
    chk("midop_d1", d1, 8'd99);
    rst = 1'b1; en = 1'b0;
    step();
    $display("midop reset: v2=%0b d2=%0d oc=%0b", v2, d2, oc2);
    chk("midop_flush_v2", v2, 1'b0);
    chk("midop_d2", d2, 8'd0);
    chk("midop_ocupado", oc2, 1'b1);
    rst = 1'b0; en = 1'b1; we = 1'b0; dir = 8'd5;
    count_sweep(n, sv);
    $display("resweep: ocupado cycles=%0d", n);
    chk("resweep_len", n, 12);
    chk("resweep_no_valid", sv, 1'b0);

    // Second sweep cleared the word written earlier
    en = 1'b1; we = 1'b0; dir = 8'd5;
    step();
    en = 1'b0;
    $display("post sweep read 5: v1=%0b d1=%0d", v1, d1);
    chk("resweep_v1", v1, 1'b1);
    chk("resweep_d1", d1, 8'd0);
    step();
    chk("resweep_v2", v2, 1'b1);
    chk("resweep_d2", d2, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
